// File: rtl/mem_ctrl_pkg.sv
// Shared types for the MEM-stage data SRAM-like bus controller:
// FSM state encoding and access size codes.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    CANCEL = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/mem_sram_ctrl.sv
// MEM-stage data-side SRAM-like bus sequencer: issues one request per memory
// instruction, holds the stage until data_ok, and withdraws or drains on flush.
module mem_sram_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_valid,
  input  logic              MEM_mem_en,
  input  logic              MEM_wr,
  input  logic [1:0]        MEM_size,
  input  logic [ADDR_W-1:0] MEM_addr,
  input  logic [DATA_W-1:0] MEM_wdata,
  input  logic              MEM_addr_exc,
  input  logic              exception_flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] MEM_rdata,
  output logic              MEM_stall,
  output logic              MEM_invalid
);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_op;
  logic                go;

  assign mem_op = MEM_valid & MEM_mem_en & ~MEM_addr_exc;
  assign go     = mem_op & ~exception_flush;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = REQ;
          wr_d    = MEM_wr;
          size_d  = MEM_size;
          addr_d  = MEM_addr;
          wdata_d = MEM_wdata;
        end
      end
      REQ: begin
        // An accepted request must still be drained even if it is being killed.
        if (exception_flush) state_d = data_addr_ok ? CANCEL : IDLE;
        else if (data_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (exception_flush) state_d = data_data_ok ? IDLE : CANCEL;
        else if (data_data_ok) state_d = IDLE;
      end
      CANCEL: begin
        if (data_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

  // Only a live response in WAIT releases the stage; a drained one in CANCEL does not.
  assign MEM_stall   = go & ~((state_q == WAIT) & data_data_ok);
  assign MEM_invalid = exception_flush;
  assign MEM_rdata   = data_rdata;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: directed vector table, hand-written
// multi-cycle corner sequences, and randomized traffic against a transaction model.
module tb_mem_sram_ctrl;

  typedef struct {
    logic        valid;
    logic        mem_en;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_exc;
    logic        flush;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        exp_req;
    logic        exp_stall;
    logic        exp_inv;
    logic [31:0] exp_addr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_valid, MEM_mem_en, MEM_wr, MEM_addr_exc, exception_flush;
  logic [1:0]  MEM_size;
  logic [31:0] MEM_addr, MEM_wdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, MEM_rdata;
  logic        MEM_stall, MEM_invalid;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  mem_sram_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .MEM_valid(MEM_valid), .MEM_mem_en(MEM_mem_en), .MEM_wr(MEM_wr),
    .MEM_size(MEM_size), .MEM_addr(MEM_addr), .MEM_wdata(MEM_wdata),
    .MEM_addr_exc(MEM_addr_exc), .exception_flush(exception_flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .MEM_rdata(MEM_rdata), .MEM_stall(MEM_stall), .MEM_invalid(MEM_invalid)
  );

  always #5 clk = ~clk;

  // Transaction-level model: at most one pending request and one accepted
  // transaction, the latter marked dead once a flush has killed its owner.
  logic        m_pend, m_acc, m_dead;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 0; m_acc <= 0; m_dead <= 0;
      m_wr <= 0; m_size <= 0; m_addr <= 0; m_wdata <= 0;
    end else if (m_pend) begin
      if (data_addr_ok) begin
        m_pend <= 0; m_acc <= 1; m_dead <= exception_flush;
      end else if (exception_flush) begin
        m_pend <= 0;
      end
    end else if (m_acc) begin
      if (data_data_ok) begin
        m_acc <= 0; m_dead <= 0;
      end else if (exception_flush) begin
        m_dead <= 1;
      end
    end else if (MEM_valid && MEM_mem_en && !MEM_addr_exc && !exception_flush) begin
      m_pend <= 1;
      m_wr <= MEM_wr; m_size <= MEM_size; m_addr <= MEM_addr; m_wdata <= MEM_wdata;
    end
  end

  function automatic stim_t mk(logic v, logic me, logic wr, logic [1:0] sz,
                               logic [31:0] a, logic [31:0] wd, logic exc, logic fl,
                               logic aok, logic dok, logic [31:0] rd);
    stim_t s;
    s.valid = v; s.mem_en = me; s.wr = wr; s.size = sz; s.addr = a; s.wdata = wd;
    s.addr_exc = exc; s.flush = fl; s.addr_ok = aok; s.data_ok = dok; s.rdata = rd;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(0, 0, 0, 2'd0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
  endfunction

  task automatic applyStimulus(input stim_t s);
    MEM_valid = s.valid; MEM_mem_en = s.mem_en; MEM_wr = s.wr; MEM_size = s.size;
    MEM_addr = s.addr; MEM_wdata = s.wdata; MEM_addr_exc = s.addr_exc;
    exception_flush = s.flush; data_addr_ok = s.addr_ok; data_data_ok = s.data_ok;
    data_rdata = s.rdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input stim_t s);
    @(negedge clk);
    applyStimulus(s);
    #1;
  endtask

  task automatic addVec(input stim_t s, input logic er, input logic es, input logic ei,
                        input logic [31:0] ea);
    vec_t v;
    v.s = s; v.exp_req = er; v.exp_stall = es; v.exp_inv = ei; v.exp_addr = ea;
    vecs.push_back(v);
  endtask

  initial begin
    stim_t s;
    stim_t ld;
    rst = 1;
    applyStimulus(idle());
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checkOutput("reset_req", {31'b0, data_req}, 32'd0);
    checkOutput("reset_addr", data_addr, 32'd0);
    checkOutput("reset_wdata", data_wdata, 32'd0);
    checkOutput("reset_wr_size", {29'b0, data_wr, data_size}, 32'd0);
    checkOutput("reset_stall", {31'b0, MEM_stall}, 32'd0);
    checkOutput("reset_invalid", {31'b0, MEM_invalid}, 32'd0);

    // Minimum-latency load, flush in REQ, and an address-exception load.
    ld = mk(1, 1, 0, 2'd2, 32'h80001000, 32'h0, 0, 0, 0, 0, 32'h0);
    addVec(ld, 0, 1, 0, 32'h0);
    s = ld; s.addr_ok = 1;                  addVec(s, 1, 1, 0, 32'h80001000);
    s = ld; s.data_ok = 1; s.rdata = 32'hDEADBEEF; addVec(s, 0, 0, 0, 32'h0);
    addVec(idle(), 0, 0, 0, 32'h0);
    ld = mk(1, 1, 0, 2'd2, 32'h80002000, 32'h0, 0, 0, 0, 0, 32'h0);
    addVec(ld, 0, 1, 0, 32'h0);
    s = ld; s.flush = 1;                    addVec(s, 1, 0, 1, 32'h80002000);
    addVec(idle(), 0, 0, 0, 32'h0);
    s = idle(); s.data_ok = 1; s.rdata = 32'h12345678; addVec(s, 0, 0, 0, 32'h0);
    s = mk(1, 1, 0, 2'd2, 32'h80000001, 32'h0, 1, 0, 0, 0, 32'h0);
    addVec(s, 0, 0, 0, 32'h0);
    addVec(s, 0, 0, 0, 32'h0);
    addVec(idle(), 0, 0, 0, 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].s);
      checkOutput($sformatf("vec%0d_req", i), {31'b0, data_req}, {31'b0, vecs[i].exp_req});
      checkOutput($sformatf("vec%0d_stall", i), {31'b0, MEM_stall}, {31'b0, vecs[i].exp_stall});
      checkOutput($sformatf("vec%0d_invalid", i), {31'b0, MEM_invalid}, {31'b0, vecs[i].exp_inv});
      checkOutput($sformatf("vec%0d_rdata", i), MEM_rdata, vecs[i].s.rdata);
      if (vecs[i].exp_req)
        checkOutput($sformatf("vec%0d_addr", i), data_addr, vecs[i].exp_addr);
    end

    // Store byte with delayed addr_ok; MEM inputs are disturbed to prove the latch holds.
    s = mk(1, 1, 1, 2'd0, 32'h80000003, 32'h000000AB, 0, 0, 0, 0, 32'h0);
    step(s);
    checkOutput("sb_first_stall", {31'b0, MEM_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      s.addr = 32'h0BAD0000 + i; s.wdata = 32'hFFFF0000 + i; s.size = 2'd2; s.wr = 0;
      s.addr_ok = (i == 3);
      step(s);
      checkOutput("sb_req", {31'b0, data_req}, 32'd1);
      checkOutput("sb_addr", data_addr, 32'h80000003);
      checkOutput("sb_wdata", data_wdata, 32'h000000AB);
      checkOutput("sb_wr_size", {29'b0, data_wr, data_size}, {29'b0, 1'b1, 2'd0});
      checkOutput("sb_req_stall", {31'b0, MEM_stall}, 32'd1);
    end
    s.addr_ok = 0;
    step(s);
    checkOutput("sb_wait_req", {31'b0, data_req}, 32'd0);
    checkOutput("sb_wait_stall", {31'b0, MEM_stall}, 32'd1);
    s.data_ok = 1;
    step(s);
    checkOutput("sb_done_stall", {31'b0, MEM_stall}, 32'd0);
    step(idle());
    checkOutput("sb_after_req", {31'b0, data_req}, 32'd0);

    // Flush in WAIT, stale response four cycles later while a new load waits.
    ld = mk(1, 1, 0, 2'd2, 32'h80003000, 32'h0, 0, 0, 0, 0, 32'h0);
    step(ld);
    s = ld; s.addr_ok = 1; step(s);
    s = ld; s.flush = 1; step(s);
    checkOutput("fw_invalid", {31'b0, MEM_invalid}, 32'd1);
    checkOutput("fw_flush_stall", {31'b0, MEM_stall}, 32'd0);
    ld = mk(1, 1, 0, 2'd2, 32'h80004000, 32'h0, 0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(ld);
      checkOutput("fw_cancel_req", {31'b0, data_req}, 32'd0);
      checkOutput("fw_cancel_stall", {31'b0, MEM_stall}, 32'd1);
    end
    s = ld; s.data_ok = 1; s.rdata = 32'h11111111; step(s);
    checkOutput("fw_stale_stall", {31'b0, MEM_stall}, 32'd1);
    checkOutput("fw_stale_req", {31'b0, data_req}, 32'd0);
    step(ld);
    checkOutput("fw_relatch_req", {31'b0, data_req}, 32'd0);
    checkOutput("fw_relatch_stall", {31'b0, MEM_stall}, 32'd1);
    s = ld; s.addr_ok = 1; step(s);
    checkOutput("fw_new_req", {31'b0, data_req}, 32'd1);
    checkOutput("fw_new_addr", data_addr, 32'h80004000);
    s = ld; s.data_ok = 1; s.rdata = 32'h22222222; step(s);
    checkOutput("fw_new_done_stall", {31'b0, MEM_stall}, 32'd0);
    checkOutput("fw_new_rdata", MEM_rdata, 32'h22222222);
    step(idle());

    // Reset asserted in WAIT, then a stray data_ok.
    ld = mk(1, 1, 1, 2'd1, 32'h80005002, 32'h5A5A0000, 0, 0, 0, 0, 32'h0);
    step(ld);
    s = ld; s.addr_ok = 1; step(s);
    step(ld);
    rst = 1;
    @(negedge clk);
    rst = 0;
    s = idle(); s.data_ok = 1; applyStimulus(s);
    #1;
    checkOutput("rst_req", {31'b0, data_req}, 32'd0);
    checkOutput("rst_addr", data_addr, 32'd0);
    checkOutput("rst_wdata", data_wdata, 32'd0);
    checkOutput("rst_wr_size", {29'b0, data_wr, data_size}, 32'd0);
    checkOutput("rst_stall", {31'b0, MEM_stall}, 32'd0);
    step(idle());
    checkOutput("rst_stray_req", {31'b0, data_req}, 32'd0);

    // Randomized traffic against the transaction model.
    for (int i = 0; i < 600; i++) begin
      s = mk($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, 1'($urandom),
             2'($urandom_range(0, 2)), $urandom, $urandom, $urandom_range(0, 9) == 0,
             $urandom_range(0, 11) == 0, 1'($urandom), $urandom_range(0, 9) < 4, $urandom);
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      applyStimulus(s);
      #1;
      checkOutput("rnd_req", {31'b0, data_req}, {31'b0, m_pend});
      checkOutput("rnd_addr", data_addr, m_addr);
      checkOutput("rnd_wdata", data_wdata, m_wdata);
      checkOutput("rnd_wr_size", {29'b0, data_wr, data_size}, {29'b0, m_wr, m_size});
      checkOutput("rnd_stall", {31'b0, MEM_stall},
                  {31'b0, s.valid & s.mem_en & ~s.addr_exc & ~s.flush &
                          ~(m_acc & ~m_dead & s.data_ok)});
      checkOutput("rnd_invalid", {31'b0, MEM_invalid}, {31'b0, s.flush});
      checkOutput("rnd_rdata", MEM_rdata, s.rdata);
    end

    @(negedge clk);
    rst = 0;
    applyStimulus(idle());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
